// File: rtl/nios_system_cpu_jtag_scan_master.sv
// Host-side scan engine for the CPU virtual-JTAG debug port.
// Runs one IR+DR scan per accepted command: UIR, CDR, SDR (DR_WIDTH bits, LSB first),
// UDR and RTI, each a whole number of generated TCK periods, then pulses rsp_valid with
// the captured TDO bits.
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   cmd_ir, cmd_dr       instruction and data for the scan (sampled at acceptance)
//   rsp_valid, rsp_dr    one-cycle completion pulse; captured data held until next response
//   vji_tck/tdi/tdo      generated TCK, serial data out, serial data in
//   vji_ir_in            instruction held from acceptance to next acceptance
//   vji_uir/cdr/sdr/udr/rti  virtual state strobes
module nios_system_cpu_jtag_scan_master #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned Period = 2 * TCK_HALF;
  localparam int unsigned CntW   = $clog2(Period);
  localparam int unsigned BitW   = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(Period - 1);
  localparam logic [CntW-1:0] CntRise = CntW'(TCK_HALF - 1);  // last low cycle before TCK rises
  localparam logic [CntW-1:0] CntHigh = CntW'(TCK_HALF);
  localparam logic [BitW-1:0] BitLast = BitW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRti,
    StRsp
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     tck_cnt_q, tck_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DR_WIDTH-1:0] shreg_q, shreg_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [4:0]          strb_q, strb_d;  // {rti, udr, sdr, cdr, uir}

  logic in_scan_q, in_scan_d, period_end;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ir_d      = ir_q;
    rsp_dr_d  = rsp_dr_q;

    in_scan_q  = state_q inside {StUir, StCdr, StSdr, StUdr, StRti};
    period_end = (tck_cnt_q == CntLast);
    tck_cnt_d  = (in_scan_q && !period_end) ? tck_cnt_q + 1'b1 : '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          shreg_d   = cmd_dr;
          ir_d      = cmd_ir;
          bit_cnt_d = '0;
          state_d   = StUir;
        end
      end
      StUir: if (period_end) state_d = StCdr;
      StCdr: if (period_end) state_d = StSdr;
      StSdr: begin
        // Sample TDO on the clk edge where TCK goes high.
        if (tck_cnt_q == CntRise) shreg_d = {vji_tdo, shreg_q[DR_WIDTH-1:1]};
        if (period_end) begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StUdr;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StUdr: if (period_end) state_d = StRti;
      StRti: if (period_end) state_d = StRsp;
      StRsp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are computed from the next state.
    in_scan_d   = state_d inside {StUir, StCdr, StSdr, StUdr, StRti};
    tck_d       = in_scan_d && (tck_cnt_d >= CntHigh);
    strb_d      = {state_d == StRti, state_d == StUdr, state_d == StSdr,
                   state_d == StCdr, state_d == StUir};
    rsp_valid_d = (state_d == StRsp);
    if (state_d == StRsp) rsp_dr_d = shreg_q;

    // TDI changes only at a period start; by then shreg[0] holds the next unsent bit.
    tdi_d = 1'b0;
    if (state_d == StSdr) tdi_d = (tck_cnt_d == '0) ? shreg_d[0] : tdi_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tck_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ir_q        <= '0;
      rsp_dr_q    <= '0;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      tck_cnt_q   <= tck_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ir_q        <= ir_d;
      rsp_dr_q    <= rsp_dr_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      strb_q      <= strb_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = strb_q[0];
  assign vji_cdr   = strb_q[1];
  assign vji_sdr   = strb_q[2];
  assign vji_udr   = strb_q[3];
  assign vji_rti   = strb_q[4];

endmodule

// File: tb/tb_nios_system_cpu_jtag_scan_master.sv
// Bench for the virtual-JTAG scan master: two instances (TCK_HALF=2 and TCK_HALF=1), each
// driving a 38-bit shift-register target that shifts on TCK rise. Expected responses are
// queued when commands are issued and checked by a monitor on rsp_valid.
module tb_nios_system_cpu_jtag_scan_master;

  localparam logic [37:0] P1 = 38'h2A_5A5A_5A5A;
  localparam logic [37:0] D1 = 38'h15_A5A5_A5A5;
  localparam logic [37:0] D2 = 38'h3F_0000_FFFF;
  localparam logic [37:0] D3 = 38'h01_2345_6789;
  localparam logic [37:0] D4 = 38'h33_CCCC_3333;
  localparam logic [37:0] P2 = 38'h0C_3C3C_C3C3;

  typedef struct packed {
    logic [37:0] dr;
    logic [1:0]  ir;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  // Instance 0 (TCK_HALF=2)
  logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  cmd_ir = '0, vji_ir_in;
  logic [37:0] cmd_dr = '0, rsp_dr;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [4:0]  strb;

  // Instance 1 (TCK_HALF=1)
  logic        c1_valid = 1'b0, c1_ready, c1_rsp_valid, c1_tck, c1_tdi, c1_tdo;
  logic [1:0]  c1_ir = '0, c1_ir_in;
  logic [37:0] c1_dr = '0, c1_rsp_dr;
  logic        c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti;

  // Targets
  logic        tgt_load = 1'b0;
  logic [37:0] tgt_init = '0;
  logic [37:0] tgt, tgt1;

  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int rsp_count = 0, rsp1_count = 0;
  int tdi_viol = 0, oh_viol = 0;
  int rise_all = 0, n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
  int acc1 = 0;
  logic [37:0] exp1_dr = '0;
  logic udr_prev = 1'b0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic [37:0] tgt_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign strb    = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};
  assign vji_tdo = tgt[0];
  assign c1_tdo  = tgt1[0];

  always @(posedge vji_tck or posedge tgt_load) begin
    if (tgt_load) tgt <= tgt_init;
    else if (vji_sdr) tgt <= {vji_tdi, tgt[37:1]};
  end

  always @(posedge c1_tck or posedge tgt_load) begin
    if (tgt_load) tgt1 <= tgt_init;
    else if (c1_sdr) tgt1 <= {c1_tdi, tgt1[37:1]};
  end

  nios_system_cpu_jtag_scan_master #(
    .DR_WIDTH(38), .IR_WIDTH(2), .TCK_HALF(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_dr(rsp_dr),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti)
  );

  nios_system_cpu_jtag_scan_master #(
    .DR_WIDTH(38), .IR_WIDTH(2), .TCK_HALF(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_ir(c1_ir), .cmd_dr(c1_dr), .rsp_valid(c1_rsp_valid), .rsp_dr(c1_rsp_dr),
    .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_tdo(c1_tdo), .vji_ir_in(c1_ir_in),
    .vji_uir(c1_uir), .vji_cdr(c1_cdr), .vji_sdr(c1_sdr), .vji_udr(c1_udr),
    .vji_rti(c1_rti)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [37:0] v);
    tgt_init = v;
    #1 tgt_load = 1'b1;
    #1 tgt_load = 1'b0;
  endtask

  task automatic send(input logic [1:0] ir, input logic [37:0] dr, input bit also1);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    if (also1) begin
      c1_valid = 1'b1; c1_ir = ir; c1_dr = dr;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c1_valid  = 1'b0;
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rsp_count >= n) break;
    end
    chk("rsp_arrived", 64'(rsp_count >= n), 64'd1);
  endtask

  initial begin
    int u0, c0, s0, d0, r0, base, rc, rsp1_cyc, acc2_cyc;
    bit got_rsp1, got_acc2;
    exp_t e;
    int a;

    fork
      forever begin
        @(posedge vji_tck);
        rise_all++;
        if (vji_uir) n_uir++;
        if (vji_cdr) n_cdr++;
        if (vji_sdr) n_sdr++;
        if (vji_udr) n_udr++;
        if (vji_rti) n_rti++;
      end
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          exp_q.delete();
          acc_q.delete();
          tgt_q.delete();
        end else begin
          if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
          if (c1_valid && c1_ready) acc1 = cyc + 1;
          if (!vji_sdr && vji_tdi) tdi_viol++;
          if ($countones(strb) > 1) oh_viol++;
          if (vji_udr && !udr_prev) begin
            if (tgt_q.size() == 0) chk("udr_unexpected", 64'(tgt_q.size()), 64'd1);
            else chk("target_at_udr", 64'(tgt), 64'(tgt_q.pop_front()));
          end
          if (rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
              chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
              e = exp_q.pop_front();
              a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
              chk("rsp_dr", 64'(rsp_dr), 64'(e.dr));
              chk("rsp_ir", 64'(vji_ir_in), 64'(e.ir));
              chk("rsp_latency", 64'(cyc - a), 64'd168);
            end
          end
          if (c1_rsp_valid) begin
            rsp1_count++;
            chk("rsp_dr_tck1", 64'(c1_rsp_dr), 64'(exp1_dr));
            chk("rsp_latency_tck1", 64'(cyc - acc1), 64'd84);
          end
        end
        udr_prev = vji_udr;
      end
      begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset with a command pending: everything at reset values.
    #1 reset_n = 1'b0;
    cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_dr = '1;
    c1_valid  = 1'b1; c1_ir  = 2'b11; c1_dr  = '1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_dr", 64'(rsp_dr), 64'd0);
    chk("rst_tck", 64'(vji_tck), 64'd0);
    chk("rst_tdi", 64'(vji_tdi), 64'd0);
    chk("rst_ir_in", 64'(vji_ir_in), 64'd0);
    chk("rst_strobes", 64'(strb), 64'd0);
    chk("rst_rsp_dr_tck1", 64'(c1_rsp_dr), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c1_valid  = 1'b0;
    #2 reset_n = 1'b1;
    base = rise_all;
    repeat (10) @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_tck", 64'(vji_tck), 64'd0);
    chk("idle_no_tck_rises", 64'(rise_all), 64'(base));

    // Single scan on both instances against preloaded targets.
    @(negedge clk);
    preload(P1);
    exp_q.push_back('{dr: P1, ir: 2'b01});
    tgt_q.push_back(D1);
    exp1_dr = P1;
    u0 = n_uir; c0 = n_cdr; s0 = n_sdr; d0 = n_udr; r0 = n_rti;
    send(2'b01, D1, 1'b1);
    wait_rsp(1);
    chk("rises_uir", 64'(n_uir - u0), 64'd1);
    chk("rises_cdr", 64'(n_cdr - c0), 64'd1);
    chk("rises_sdr", 64'(n_sdr - s0), 64'd38);
    chk("rises_udr", 64'(n_udr - d0), 64'd1);
    chk("rises_rti", 64'(n_rti - r0), 64'd1);
    repeat (3) @(negedge clk);
    chk("ir_after_scan", 64'(vji_ir_in), 64'd1);
    chk("ready_after_scan", 64'(cmd_ready), 64'd1);
    chk("target1_after_scan", 64'(tgt1), 64'(D1));
    chk("rsp_count_tck1", 64'(rsp1_count), 64'd1);

    // Busy then back-to-back: command held valid, contents changed mid-scan.
    exp_q.push_back('{dr: D1, ir: 2'b10});
    exp_q.push_back('{dr: D2, ir: 2'b11});
    tgt_q.push_back(D2);
    tgt_q.push_back(D3);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_ir = 2'b10; cmd_dr = D2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk); #1;
    cmd_ir = 2'b11; cmd_dr = D3;
    got_rsp1 = 1'b0; got_acc2 = 1'b0; rsp1_cyc = 0; acc2_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_rsp1 = 1'b1;
        rsp1_cyc = cyc;
      end
      if (cmd_ready) begin
        got_acc2 = 1'b1;
        acc2_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_first_rsp_seen", 64'(got_rsp1), 64'd1);
    chk("b2b_second_accept_seen", 64'(got_acc2), 64'd1);
    chk("b2b_accept_after_rsp", 64'(acc2_cyc - rsp1_cyc), 64'd1);
    wait_rsp(3);
    repeat (2) @(negedge clk);
    chk("b2b_ir_held", 64'(vji_ir_in), 64'd3);

    // Reset in the middle of SDR, then a fresh scan.
    @(negedge clk);
    preload(P1);
    exp_q.push_back('{dr: P1, ir: 2'b01});
    tgt_q.push_back(D1);
    base = n_sdr;
    send(2'b01, D1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_sdr - base >= 20) break;
    end
    chk("mid_sdr_reached", 64'(n_sdr - base), 64'd20);
    chk("mid_sdr_active", 64'(vji_sdr), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_sdr", 64'(vji_sdr), 64'd0);
    chk("mid_rst_tck", 64'(vji_tck), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rc = rsp_count;
    repeat (250) @(negedge clk);
    chk("mid_rst_no_rsp", 64'(rsp_count), 64'(rc));
    preload(P2);
    exp_q.push_back('{dr: P2, ir: 2'b01});
    tgt_q.push_back(D4);
    send(2'b01, D4, 1'b0);
    wait_rsp(rc + 1);
    repeat (3) @(negedge clk);

    chk("tdi_outside_sdr", 64'(tdi_viol), 64'd0);
    chk("strobes_onehot", 64'(oh_viol), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("udr_checks_drained", 64'(tgt_q.size()), 64'd0);
    chk("rsp_count_final_tck1", 64'(rsp1_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios_system_cpu_jtag_scan_master.md
# nios_system_cpu_jtag_scan_master

Host-side scan engine for the CPU's virtual-JTAG debug port. It drives the `vji_*` signal set that the debug module's TCK-side logic consumes: TCK, TDI, the 2-bit IR and the UIR/CDR/SDR/UDR/RTI state strobes. It captures TDO from the same port. It sits in the system clock domain and lets on-chip logic or a bench issue one IR+DR scan per command, without a physical JTAG cable.

## Interface
Parameters:
- `DR_WIDTH`, 38, data-register scan length in bits.
- `IR_WIDTH`, 2, instruction-register width.
- `TCK_HALF`, 2, clk cycles per TCK half-period; legal values are 1 or greater.

Ports:
- `clk`  in  1  the single clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  a scan command is presented.
- `cmd_ready`  out  1  the engine is idle and accepts a command.
- `cmd_ir`  in  IR_WIDTH  instruction to present on `vji_ir_in`.
- `cmd_dr`  in  DR_WIDTH  data to shift out, LSB first.
- `rsp_valid`  out  1  one-cycle pulse; the scan is complete.
- `rsp_dr`  out  DR_WIDTH  captured TDO bits; held until the next response.
- `vji_tck`  out  1  generated TCK.
- `vji_tdi`  out  1  serial data to the target.
- `vji_tdo`  in  1  serial data from the target.
- `vji_ir_in`  out  IR_WIDTH  current instruction.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual state strobes.

## Operation
- States are IDLE, UIR, CDR, SDR, UDR, RTI and RSP.
- Every state except IDLE and RSP lasts a whole number of TCK periods. One period is 2*TCK_HALF clk cycles: TCK is low for the first TCK_HALF cycles and high for the last TCK_HALF cycles.
- **IDLE:**
  - `cmd_ready`=1 and TCK=0.
  - On `cmd_valid && cmd_ready`, register `cmd_dr` into the shift register and `cmd_ir` into `vji_ir_in`, then go to UIR.
- **UIR:** 1 period, `vji_uir`=1.
- **CDR:** 1 period, `vji_cdr`=1.
- **SDR:** DR_WIDTH periods, `vji_sdr`=1.
  - During period k (k=0..DR_WIDTH-1), `vji_tdi` = `cmd_dr[k]`.
  - `vji_tdo` is sampled on the clk edge where TCK goes 0→1.
  - The sampled bit enters the shift register MSB; the register shifts right. After DR_WIDTH shifts, captured bit k is the bit sampled in period k.
- **UDR:** 1 period, `vji_udr`=1.
- **RTI:** 1 period, `vji_rti`=1.
- **RSP:** 1 clk cycle.
  - `rsp_valid`=1 and `rsp_dr` is loaded from the shift register.
  - Next state is IDLE.
- Exactly one state strobe is high in each of UIR, CDR, SDR, UDR and RTI. All strobes are 0 in IDLE and RSP.
- `vji_tdi`=0 outside SDR.
- `vji_ir_in` holds its value from acceptance until the next acceptance.
- `cmd_valid` while the engine is busy is ignored. The command inputs are sampled only at acceptance.
- There is no response backpressure. `rsp_valid` is a pulse and the consumer must take it.

## Timing
- Reset values:
  - state=IDLE, so `cmd_ready`=1.
  - `rsp_valid`=0 and `rsp_dr`=0.
  - `vji_tck`=0 and `vji_tdi`=0.
  - `vji_ir_in`=0.
  - All strobes=0.
- All outputs except `cmd_ready` are registered. `cmd_ready` is decoded from the state.
- Acceptance edge E0: the UIR state and its first TCK-low cycle begin on the cycle after E0.
- `rsp_valid` is high in the cycle beginning exactly (DR_WIDTH+4)*2*TCK_HALF clk edges after E0. With defaults this is 168 edges.
- `cmd_ready` returns to 1 in the cycle after `rsp_valid`, so back-to-back commands are possible with a 1-cycle gap.
- The TCK-period counter runs from 0 to 2*TCK_HALF-1 and wraps. The bit counter runs from 0 to DR_WIDTH-1; SDR exits after the last period.
- With TCK_HALF=1, TCK toggles every clk cycle and sampling still occurs on the 0→1 edge.
- Reset asserted mid-scan: all outputs take reset values immediately and asynchronously. No `rsp_valid` is produced, and the next command starts a fresh sequence from UIR.

## Test plan
- **Reset:** drive `reset_n` low while `cmd_valid`=1 → all outputs at reset values. After release, `cmd_ready`=1 and TCK stays 0 with no command.
- **Single scan against a 38-bit shift-register target model** (target shifts on TCK rise, preloaded with 38'h2A_5A5A_5A5A): send IR=2'b01, DR=38'h15_A5A5_A5A5 → `rsp_dr`=38'h2A_5A5A_5A5A, and the target holds 38'h15_A5A5_A5A5 at the UDR strobe. `rsp_valid` is high in the cycle beginning 168 edges after acceptance.
- **Strobe sequence:** count TCK rises per strobe → UIR 1, CDR 1, SDR 38, UDR 1, RTI 1, and strobes are never simultaneously high. `vji_ir_in`=2'b01 throughout and after completion.
- **Busy and back-to-back:** hold `cmd_valid`=1 with IR=2 then IR=3 changing mid-scan → the second command is accepted only in the cycle after the first `rsp_valid`. Its IR=3 appears on `vji_ir_in`, and the first scan's IR stays 2.
- **TCK_HALF=1:** run the same scan with TCK_HALF=1 → `rsp_valid` in the cycle beginning 84 edges after acceptance, with identical `rsp_dr`.
- **Reset mid-SDR:** assert `reset_n` low at bit 20 → `vji_sdr`=0 and TCK=0 immediately, with no `rsp_valid`. A subsequent full scan completes correctly.
